// File: rtl/crypt_block_sequencer_pkg.sv
// Shared definitions for the block encrypt/decrypt sequencer: opcodes,
// word width, mode encoding and the sequencer state encoding.
package crypt_block_sequencer_pkg;

    // CPU opcodes that launch the sequencer.
    localparam logic [4:0] OP_ENC = 5'b10010;
    localparam logic [4:0] OP_DEC = 5'b10011;

    // Machine word width.
    localparam int DATA_W = 19;

    // Value of the mode input for each direction.
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Width of a word counter that reaches len-1 (never narrower than one bit).
    function automatic int idx_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/crypt_word_xform.sv
// Combinational per-word transform used on the copy path.
//   encrypt: out = (d ^ key) + idx
//   decrypt: out = (d - idx) ^ key
// All arithmetic wraps at the word width; idx is zero-extended.
module crypt_word_xform
    import crypt_block_sequencer_pkg::*;
#(
    parameter int WORD_W = DATA_W,
    parameter int IDX_W  = 3
) (
    input  logic [WORD_W-1:0] data,
    input  logic [WORD_W-1:0] key,
    input  logic [IDX_W-1:0]  idx,
    input  logic              mode,
    output logic [WORD_W-1:0] result
);

    logic [WORD_W-1:0] idx_ext;

    // Select the transform direction; decrypt undoes encrypt step by step in reverse.
    always_comb begin
        idx_ext = WORD_W'(idx);
        if (mode == MODE_DEC) begin
            result = (data - idx_ext) ^ key;
        end else begin
            result = (data ^ key) + idx_ext;
        end
    end

endmodule

// File: rtl/crypt_block_sequencer.sv
// Block encrypt/decrypt sequencer. Copies LEN words from src to dst through
// a shared request/grant memory port, transforming each word in flight.
// Only one memory access is ever outstanding: read word, wait for data,
// write word, then move to the next index.
module crypt_block_sequencer #(
    parameter int DATA_W = crypt_block_sequencer_pkg::DATA_W,
    parameter int ADDR_W = 16,
    parameter int LEN    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [DATA_W-1:0] key,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    import crypt_block_sequencer_pkg::*;

    localparam int IDX_W = idx_width(LEN);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              mode_q,  mode_d;
    logic [ADDR_W-1:0] src_q,   src_d;
    logic [ADDR_W-1:0] dst_q,   dst_d;
    logic [DATA_W-1:0] key_q,   key_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] xform_out;

    crypt_word_xform #(
        .WORD_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_xform (
        .data   (mem_rdata),
        .key    (key_q),
        .idx    (idx_q),
        .mode   (mode_q),
        .result (xform_out)
    );

    // State and operand registers; reset clears everything so the port comes up idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            key_q   <= '0;
            wdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            key_q   <= key_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state and output decode; request outputs come straight from the state so reset drops them at once.
    always_comb begin
        // NOTE: every output and next-state value gets a default first so no latch is inferred.
        state_d  = state_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        src_d    = src_q;
        dst_d    = dst_q;
        key_d    = key_q;
        wdata_d  = wdata_q;
        busy     = 1'b1;
        done     = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;

        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    mode_d  = mode;
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    key_d   = key;
                    idx_d   = '0;
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = src_q + ADDR_W'(idx_q);
                if (mem_gnt) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rvalid) begin
                    wdata_d = xform_out;
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = dst_q + ADDR_W'(idx_q);
                if (mem_gnt) begin
                    if (idx_q == IDX_W'(LEN - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_wdata = wdata_q;

endmodule

// File: doc/crypt_block_sequencer.md
Name: crypt_block_sequencer

Overview:
- Multi-cycle controller that executes the CPU's block encrypt (opcode 10010) and decrypt (opcode 10011) instructions.
- Copies LEN words from a source address to a destination address in data memory. Each word is transformed in flight.
- Reaches memory through a request/grant port that the memory arbiter shares with the CPU load/store path.
- The CPU stalls while busy=1 and resumes on done.

Parameters:
- DATA_W, 19, machine word width.
- ADDR_W, 16, data memory address width.
- LEN, 8, words per block operation (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle launch strobe from the decoder.
- mode  in  1  0=encrypt, 1=decrypt; sampled with start.
- src_addr  in  ADDR_W  first source word address (low bits of rs); sampled with start.
- dst_addr  in  ADDR_W  first destination word address (low bits of rd); sampled with start.
- key  in  DATA_W  block key; sampled with start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse after the last write is granted.
- mem_req  out  1  memory access request.
- mem_we  out  1  1=write, 0=read; valid while mem_req=1.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data.
- mem_gnt  in  1  arbiter accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset (async, rst=1): state=IDLE, idx=0. busy, done, mem_req and mem_we are 0. mem_addr, mem_wdata and the latched operands are 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE:
  - start=1 at a clock edge latches mode, src, dst and key, clears idx, and moves to RD_REQ.
  - start is ignored in every other state.
- RD_REQ:
  - Drives mem_req=1, mem_we=0, mem_addr=(src+idx) mod 2^ADDR_W.
  - Holds all of these unchanged until mem_gnt=1, then moves to RD_WAIT.
- RD_WAIT:
  - mem_req=0. Waits for mem_rvalid=1, which may arrive 1 or more cycles after the grant.
  - On mem_rvalid=1, captures the transformed word into the wdata register and moves to WR_REQ.
  - mem_rvalid in any other state is ignored.
- Transform, arithmetic modulo 2^DATA_W, idx zero-extended:
  - encrypt: out = (d XOR key) + idx.
  - decrypt: out = (d - idx) XOR key.
  - decrypt(encrypt(x)) = x for every x, key and idx.
- WR_REQ:
  - Drives mem_req=1, mem_we=1, mem_addr=(dst+idx) mod 2^ADDR_W, mem_wdata=out.
  - Holds until mem_gnt=1.
  - On the grant: if idx=LEN-1, move to DONE; otherwise idx<=idx+1 and go back to RD_REQ.
- DONE: done=1 and busy=1 for exactly one cycle, then return to IDLE with busy=0.
- Latency: with mem_gnt tied high and rvalid one cycle after the grant, each word costs 3 cycles. done is asserted 3*LEN+1 cycles after the start edge (25 for LEN=8).
- Addresses wrap modulo 2^ADDR_W.
- Overlapping src/dst ranges: each word's read completes before its write. Result equals a forward word-by-word copy.
- Reset mid-operation: immediate return to IDLE and mem_req drops asynchronously. Words already written stay written; no done pulse.
- start and DONE in the same cycle: start is ignored, because the block is not in IDLE.
- At most one outstanding memory access at any time.

Decomposition:
- Shared cpu package holds:
  - opcode constants OP_ENC=5'b10010 and OP_DEC=5'b10011;
  - DATA_W=19;
  - the state enum encoding;
  - a MODE_ENC/MODE_DEC localparam pair.
- One sub-module, crypt_word_xform: combinational transform of data, key, idx and mode. It is shared with the bench's reference model.

Test Plan:
- Encrypt, zero key: mem[400..407]=10..17, src=400, dst=300, key=0, mode=0, gnt=1, rvalid one cycle after the grant -> mem[300..307]=10,12,14,16,18,20,22,24; done at cycle 25; busy high for 25 cycles.
- Round trip: encrypt mem[400..407]=10..17 to 300 with key=19'h2A5A5, then decrypt 300 to 500 with the same key -> mem[500..507]=10..17; mem[300] equals 10 XOR 19'h2A5A5.
- Grant stall: hold mem_gnt=0 for 4 cycles on the word-3 read and 2 cycles on the word-5 write -> mem_req, mem_addr and mem_wdata stable throughout the stalls; same final memory image; done 6 cycles later than the no-stall run.
- Address wrap: src=16'hFFFE, dst=16'hFFFC, LEN=8 -> reads 0xFFFE, 0xFFFF, 0x0000 ... 0x0005; writes 0xFFFC ... 0x0003.
- Start while busy: second start at cycle 5 with src=0 -> ignored; addresses and done timing match the single-start run.
- Reset mid-op: assert rst during the word-4 WR_REQ -> mem_req=0 immediately; state IDLE; no done pulse; mem[300..303] written and mem[304..307] untouched; a fresh start afterwards completes normally.
